sdram_port_arbiter: RTL

- Merges the cache's two Avalon-MM miss/refill masters into the single Avalon-MM slave port of the SDRAM controller: I-side is read-only, D-side is read/write with byte enables.
- Arbitration is round-robin.
- Read responses return in issue order and are routed back by a small pending-source FIFO.
- Sits between the I/D caches and sdram_controller inside the cache subsystem.

---
 rtl/sdram_port_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter merging the I-side (read-only) and D-side (read/write) cache masters onto
// one SDRAM controller port; read responses are routed back in issue order via a source FIFO.
module sdram_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MAX_PENDING = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     i_address,
    input  logic                  i_read,
    output logic                  i_waitrequest,
    output logic [DATA_W-1:0]     i_readdata,
    output logic                  i_readdatavalid,
    input  logic [ADDR_W-1:0]     d_address,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [DATA_W/8-1:0]   d_byteenable,
    input  logic [DATA_W-1:0]     d_writedata,
    output logic                  d_waitrequest,
    output logic [DATA_W-1:0]     d_readdata,
    output logic                  d_readdatavalid,
    output logic [ADDR_W-1:0]     m_address,
    output logic                  m_read,
    output logic                  m_write,
    output logic [DATA_W/8-1:0]   m_byteenable,
    output logic [DATA_W-1:0]     m_writedata,
    input  logic                  m_waitrequest,
    input  logic [DATA_W-1:0]     m_readdata,
    input  logic                  m_readdatavalid,
    output logic                  err_unexpected_rdv
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_PENDING) + 1;
    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_PENDING);

    typedef enum logic {SrcI = 1'b0, SrcD = 1'b1} src_e;

    logic [CNT_W-1:0]       pend_count_q, pend_count_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [MAX_PENDING-1:0] fifo_q, fifo_d;
    logic                   lock_valid_q, lock_valid_d;
    src_e                   lock_src_q, lock_src_d;
    src_e                   last_src_q, last_src_d;
    logic                   err_q, err_d;
    logic [ADDR_W-1:0]      addr_hold_q, addr_hold_d;
    logic [DATA_W-1:0]      wdata_hold_q, wdata_hold_d;
    logic [BE_W-1:0]        be_hold_q, be_hold_d;

    logic read_room, i_elig, d_elig;
    logic gnt_valid, gnt_active;
    src_e gnt_src;
    logic accept, push, pop;

    // Eligibility uses the registered count only: a pop this cycle does not free a slot yet.
    assign read_room = (pend_count_q < MaxCnt);
    assign i_elig    = i_read & read_room;
    assign d_elig    = d_write | (d_read & read_room);

    always_comb begin
        gnt_valid = 1'b0;
        gnt_src   = SrcI;
        if (lock_valid_q) begin
            gnt_valid = 1'b1;
            gnt_src   = lock_src_q;
        end else if (i_elig && d_elig) begin
            gnt_valid = 1'b1;
            gnt_src   = (last_src_q == SrcI) ? SrcD : SrcI;
        end else if (d_elig) begin
            gnt_valid = 1'b1;
            gnt_src   = SrcD;
        end else if (i_elig) begin
            gnt_valid = 1'b1;
            gnt_src   = SrcI;
        end
    end

    assign gnt_active = gnt_valid & ~reset;

    always_comb begin
        m_address    = addr_hold_q;
        m_writedata  = wdata_hold_q;
        m_byteenable = be_hold_q;
        m_read       = 1'b0;
        m_write      = 1'b0;
        if (gnt_active) begin
            if (gnt_src == SrcD) begin
                m_address    = d_address;
                m_writedata  = d_writedata;
                m_byteenable = d_byteenable;
                m_write      = d_write;
                m_read       = d_read & ~d_write;
            end else begin
                m_address    = i_address;
                m_byteenable = '1;
                m_read       = i_read;
            end
        end
    end

    assign addr_hold_d  = m_address;
    assign wdata_hold_d = m_writedata;
    assign be_hold_d    = m_byteenable;

    assign i_waitrequest = ~(gnt_active && gnt_src == SrcI) | m_waitrequest;
    assign d_waitrequest = ~(gnt_active && gnt_src == SrcD) | m_waitrequest;

    assign accept = gnt_active & ~m_waitrequest;
    assign push   = accept & m_read;
    assign pop    = m_readdatavalid & (pend_count_q != '0) & ~reset;

    assign i_readdata      = m_readdata;
    assign d_readdata      = m_readdata;
    assign i_readdatavalid = pop & (fifo_q[rd_ptr_q] == SrcI);
    assign d_readdatavalid = pop & (fifo_q[rd_ptr_q] == SrcD);
    assign err_unexpected_rdv = err_q;

    always_comb begin
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        pend_count_d = pend_count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = gnt_src;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            pend_count_d = pend_count_q + 1'b1;
        end else if (pop && !push) begin
            pend_count_d = pend_count_q - 1'b1;
        end
    end

    always_comb begin
        lock_valid_d = lock_valid_q;
        lock_src_d   = lock_src_q;
        last_src_d   = last_src_q;
        if (accept) begin
            lock_valid_d = 1'b0;
            last_src_d   = gnt_src;
        end else if (gnt_active) begin
            lock_valid_d = 1'b1;
            lock_src_d   = gnt_src;
        end
    end

    assign err_d = err_q | (m_readdatavalid & (pend_count_q == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_q       <= '0;
            lock_valid_q <= 1'b0;
            lock_src_q   <= SrcI;
            last_src_q   <= SrcI;
            err_q        <= 1'b0;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
            be_hold_q    <= '0;
        end else begin
            pend_count_q <= pend_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_q       <= fifo_d;
            lock_valid_q <= lock_valid_d;
            lock_src_q   <= lock_src_d;
            last_src_q   <= last_src_d;
            err_q        <= err_d;
            addr_hold_q  <= addr_hold_d;
            wdata_hold_q <= wdata_hold_d;
            be_hold_q    <= be_hold_d;
        end
    end

endmodule
